countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- HH:MM:SS countdown timer, the down-counting counterpart of the up-counting digital clock.
- Software or panel logic loads a start time, then starts, pauses or clears the timer.
- The timer decrements once per clk_1hz edge with borrow across seconds, minutes and hours.
- On reaching 00:00:00 it issues a one-cycle done pulse and a fixed-length alarm.

Parameters:
- HOUR_MAX, 23, highest hour value accepted on load.
- ALERT_CYCLES, 5, number of clk_1hz cycles alarm stays high after expiry; must be >= 1.

Ports:
- clk_1hz    input   1  1 Hz tick clock; all logic on posedge.
- rst        input   1  reset, asynchronous, active-high.
- clear      input   1  synchronous abort; counters to zero, go to IDLE.
- load       input   1  capture load_hr/load_min/load_sec this edge.
- load_hr    input   5  load hours, 0..HOUR_MAX.
- load_min   input   6  load minutes, 0..59.
- load_sec   input   6  load seconds, 0..59.
- start      input   1  begin or resume counting.
- pause      input   1  suspend counting.
- hours      output  5  current remaining hours.
- minutes    output  6  current remaining minutes.
- seconds    output  6  current remaining seconds.
- running    output  1  high while state == RUN.
- done       output  1  one-cycle pulse when count reaches 00:00:00.
- alarm      output  1  high for ALERT_CYCLES cycles starting with done.
- load_err   output  1  one-cycle pulse on a rejected load.

Behaviour:

Reset:
- rst high: state=IDLE, hours/minutes/seconds=0, running/done/alarm/load_err=0, alarm counter=0. Asynchronous, effective immediately regardless of state.
- All outputs are registered.

States: IDLE, RUN, PAUSED, EXPIRED.

Control priority per edge: clear > load > pause > start.
- clear: counters=0, state=IDLE, done/alarm/load_err=0. Valid in any state.
- load:
  - Valid when load_sec<=59, load_min<=59 and load_hr<=HOUR_MAX. Counters take the load values.
  - RUN stays RUN (restart from the new value, no decrement this edge).
  - PAUSED stays PAUSED.
  - EXPIRED goes to IDLE; alarm and done drop this edge.
  - IDLE stays IDLE.
- Invalid load: load_err=1 for that cycle only; counters and state unchanged; other inputs that edge are ignored.
- pause:
  - RUN goes to PAUSED; no decrement on this edge.
  - Ignored in every other state.
- start:
  - IDLE or PAUSED goes to RUN when the count is nonzero; no decrement on this edge.
  - A count of 00:00:00 ignores start (stays in current state).
  - Ignored in RUN and EXPIRED.
  - start and pause together: pause wins.

RUN, no control input active: decrement once per edge.
- seconds>0: seconds-1.
- seconds==0, minutes>0: seconds=59, minutes-1.
- seconds==0, minutes==0: seconds=59, minutes=59, hours-1.
- Count 00:00:00 while in RUN is unreachable; no underflow wrap, ever.

Expiry, on the edge where the count goes 00:00:01 to 00:00:00:
- State goes to EXPIRED.
- done=1, alarm=1, alarm counter=ALERT_CYCLES-1.

EXPIRED:
- Each edge: done=0.
- Alarm counter==0: alarm=0, state=IDLE. Otherwise decrement the alarm counter.
- Result: done is high exactly 1 cycle, alarm exactly ALERT_CYCLES cycles. Counters hold 00:00:00.

Output decode: running = (state==RUN), registered with the state.

Test Plan:
1. Reset, load 00:01:02, start; run 62 edges.
   - After the 2nd counting edge: 00:01:00. Next edge: 00:00:59.
   - done=1 exactly at the 62nd counting edge with count 00:00:00; running drops the same edge.
2. Hour and full borrow.
   - Load 01:00:00, start, one counting edge -> 00:59:59.
   - Load 23:59:59 -> next count 23:59:58.
3. Invalid loads.
   - Load 00:60:00 from PAUSED at 00:00:10 -> load_err pulse 1 cycle; count stays 00:00:10; state stays PAUSED.
   - Load 24:00:00 with HOUR_MAX=23 -> rejected the same way.
4. Pause and resume.
   - Load 00:00:10, start, 3 counting edges -> 00:00:07.
   - Pause -> 00:00:07 holds 5 edges; running=0.
   - Start -> resume; done after 7 further counting edges.
   - Assert start and pause together while in RUN -> goes to PAUSED.
5. Alarm length, ALERT_CYCLES=5.
   - Expiry -> alarm high exactly 5 edges, done exactly 1, then IDLE.
   - Load during alarm -> alarm drops next edge, state IDLE.
   - Start at 00:00:00 -> ignored.
6. Abort and reset.
   - clear mid-RUN at 00:30:00 -> 00:00:00, IDLE, no done pulse.
   - Assert rst asynchronously between edges mid-alarm -> all outputs 0 immediately.

Source files
------------

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer ticking on clk_1hz, with load validation,
// pause/resume, a one-cycle done pulse and a fixed-length alarm on expiry.
module countdown_timer #(
    parameter int HOUR_MAX     = 23,
    parameter int ALERT_CYCLES = 5
) (
    input  logic       clk_1hz,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic [4:0] load_hr,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       done,
    output logic       alarm,
    output logic       load_err
);

    localparam int CNT_W = (ALERT_CYCLES > 1) ? $clog2(ALERT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [4:0]         r_hours, w_hours_nxt;
    logic [5:0]         r_minutes, w_minutes_nxt;
    logic [5:0]         r_seconds, w_seconds_nxt;
    logic [CNT_W-1:0]   r_alarm_cnt, w_alarm_cnt_nxt;
    logic               r_running, w_running_nxt;
    logic               r_done, w_done_nxt;
    logic               r_alarm, w_alarm_nxt;
    logic               r_load_err, w_load_err_nxt;

    logic               w_load_ok;
    logic               w_nonzero;
    logic               w_last_tick;

    assign w_load_ok   = (load_sec <= 6'd59) && (load_min <= 6'd59) &&
                         (load_hr <= 5'(HOUR_MAX));
    assign w_nonzero   = (r_hours != 5'd0) || (r_minutes != 6'd0) || (r_seconds != 6'd0);
    // 00:00:01 expires on this tick; a zero count reloaded while running expires too
    assign w_last_tick = (r_hours == 5'd0) && (r_minutes == 6'd0) && (r_seconds <= 6'd1);

    // State register and all registered outputs
    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hours     <= 5'd0;
            r_minutes   <= 6'd0;
            r_seconds   <= 6'd0;
            r_alarm_cnt <= '0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_alarm     <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hours     <= w_hours_nxt;
            r_minutes   <= w_minutes_nxt;
            r_seconds   <= w_seconds_nxt;
            r_alarm_cnt <= w_alarm_cnt_nxt;
            r_running   <= w_running_nxt;
            r_done      <= w_done_nxt;
            r_alarm     <= w_alarm_nxt;
            r_load_err  <= w_load_err_nxt;
        end
    end

    // Next-state, counter and output logic with clear > load > pause > start
    always_comb begin
        w_state_nxt     = r_state;
        w_hours_nxt     = r_hours;
        w_minutes_nxt   = r_minutes;
        w_seconds_nxt   = r_seconds;
        w_alarm_cnt_nxt = r_alarm_cnt;
        w_done_nxt      = 1'b0;
        w_alarm_nxt     = 1'b0;
        w_load_err_nxt  = 1'b0;

        if (clear) begin
            w_state_nxt     = S_IDLE;
            w_hours_nxt     = 5'd0;
            w_minutes_nxt   = 6'd0;
            w_seconds_nxt   = 6'd0;
            w_alarm_cnt_nxt = '0;
        end else if (load) begin
            if (w_load_ok) begin
                w_hours_nxt   = load_hr;
                w_minutes_nxt = load_min;
                w_seconds_nxt = load_sec;
                if (r_state == S_EXPIRED) begin
                    w_state_nxt     = S_IDLE;
                    w_alarm_cnt_nxt = '0;
                end else begin
                    w_state_nxt = r_state;
                end
            end else begin
                // Rejected load freezes everything else, including a live alarm
                w_load_err_nxt = 1'b1;
                w_alarm_nxt    = r_alarm;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSED;
                    end else if (w_last_tick) begin
                        w_state_nxt     = S_EXPIRED;
                        w_hours_nxt     = 5'd0;
                        w_minutes_nxt   = 6'd0;
                        w_seconds_nxt   = 6'd0;
                        w_done_nxt      = 1'b1;
                        w_alarm_nxt     = 1'b1;
                        w_alarm_cnt_nxt = CNT_W'(ALERT_CYCLES - 1);
                    end else if (r_seconds != 6'd0) begin
                        w_seconds_nxt = r_seconds - 6'd1;
                    end else if (r_minutes != 6'd0) begin
                        w_seconds_nxt = 6'd59;
                        w_minutes_nxt = r_minutes - 6'd1;
                    end else begin
                        w_seconds_nxt = 6'd59;
                        w_minutes_nxt = 6'd59;
                        w_hours_nxt   = r_hours - 5'd1;
                    end
                end
                S_IDLE, S_PAUSED: begin
                    if (start && !pause && w_nonzero) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_EXPIRED: begin
                    if (r_alarm_cnt == '0) begin
                        w_state_nxt = S_IDLE;
                        w_alarm_nxt = 1'b0;
                    end else begin
                        w_alarm_cnt_nxt = r_alarm_cnt - CNT_W'(1);
                        w_alarm_nxt     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        w_running_nxt = (w_state_nxt == S_RUN);
    end

    assign hours    = r_hours;
    assign minutes  = r_minutes;
    assign seconds  = r_seconds;
    assign running  = r_running;
    assign done     = r_done;
    assign alarm    = r_alarm;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer against a model that
// tracks the remaining time as a single count of seconds.
module tb_countdown_timer;

    localparam int HOUR_MAX     = 23;
    localparam int ALERT_CYCLES = 5;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_EXP    = 3;

    logic       clk_1hz = 1'b0;
    logic       rst;
    logic       clear, load, start, pause;
    logic [4:0] load_hr;
    logic [5:0] load_min, load_sec;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic       running, done, alarm, load_err;

    int n_tests = 0;
    int n_fail  = 0;

    int m_total      = 0;
    int m_mode       = M_IDLE;
    int m_alarm_left = 0;
    bit m_done       = 1'b0;
    bit m_err        = 1'b0;

    countdown_timer #(.HOUR_MAX(HOUR_MAX), .ALERT_CYCLES(ALERT_CYCLES)) dut (
        .clk_1hz (clk_1hz),
        .rst     (rst),
        .clear   (clear),
        .load    (load),
        .load_hr (load_hr),
        .load_min(load_min),
        .load_sec(load_sec),
        .start   (start),
        .pause   (pause),
        .hours   (hours),
        .minutes (minutes),
        .seconds (seconds),
        .running (running),
        .done    (done),
        .alarm   (alarm),
        .load_err(load_err)
    );

    always #5 clk_1hz = ~clk_1hz;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_total      = 0;
        m_mode       = M_IDLE;
        m_alarm_left = 0;
        m_done       = 1'b0;
        m_err        = 1'b0;
    endtask

    // One clock edge of the timer, expressed as arithmetic on total seconds
    task automatic model_step(input bit c, input bit l, input int h, input int mi,
                              input int s, input bit st, input bit pa);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (c) begin
            m_total      = 0;
            m_mode       = M_IDLE;
            m_alarm_left = 0;
        end else if (l) begin
            if (h <= HOUR_MAX && mi <= 59 && s <= 59) begin
                m_total = h * 3600 + mi * 60 + s;
                if (m_mode == M_EXP) begin
                    m_mode       = M_IDLE;
                    m_alarm_left = 0;
                end
            end else begin
                m_err = 1'b1;
            end
        end else begin
            case (m_mode)
                M_RUN: begin
                    if (pa) m_mode = M_PAUSED;
                    else if (m_total <= 1) begin
                        m_total      = 0;
                        m_mode       = M_EXP;
                        m_done       = 1'b1;
                        m_alarm_left = ALERT_CYCLES;
                    end else m_total = m_total - 1;
                end
                M_EXP: begin
                    m_alarm_left = m_alarm_left - 1;
                    if (m_alarm_left == 0) m_mode = M_IDLE;
                end
                default: begin
                    if (!pa && st && m_total > 0) m_mode = M_RUN;
                end
            endcase
        end
    endtask

    task automatic check_all();
        chk("hours",    int'(hours),    m_total / 3600);
        chk("minutes",  int'(minutes),  (m_total / 60) % 60);
        chk("seconds",  int'(seconds),  m_total % 60);
        chk("running",  int'(running),  int'(m_mode == M_RUN));
        chk("done",     int'(done),     int'(m_done));
        chk("alarm",    int'(alarm),    int'(m_alarm_left > 0));
        chk("load_err", int'(load_err), int'(m_err));
    endtask

    task automatic step(input bit c, input bit l, input int h, input int mi,
                        input int s, input bit st, input bit pa);
        clear    = c;
        load     = l;
        load_hr  = h[4:0];
        load_min = mi[5:0];
        load_sec = s[5:0];
        start    = st;
        pause    = pa;
        @(posedge clk_1hz);
        model_step(c, l, h, mi, s, st, pa);
        #1;
        check_all();
        clear = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_load(input int h, input int mi, input int s);
        step(1'b0, 1'b1, h, mi, s, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic do_pause();
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic do_clear();
        step(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int n_alarm;
        int n_done;
        int r;
        bit c, l, st, pa;
        int h, mi, s;

        rst = 1'b1; clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        load_hr = 5'd0; load_min = 6'd0; load_sec = 6'd0;
        model_reset();
        #1;
        check_all();
        #12;
        rst = 1'b0;

        // Basic countdown through minute borrow to expiry
        do_load(0, 1, 2);
        do_start();
        tick(2);
        chk("t1_min_after2", int'(minutes), 1);
        chk("t1_sec_after2", int'(seconds), 0);
        tick(1);
        chk("t1_sec_after3", int'(seconds), 59);
        tick(59);
        chk("t1_done", int'(done), 1);
        chk("t1_running", int'(running), 0);
        tick(6);

        // Hour borrow and full-range load while running
        do_load(1, 0, 0);
        do_start();
        tick(1);
        chk("t2_hour_borrow", int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds), 3599);
        do_load(23, 59, 59);
        tick(1);
        chk("t2_max_dec", int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds), 86398);
        do_clear();

        // Rejected loads from PAUSED
        do_load(0, 0, 10);
        do_start();
        do_pause();
        do_load(0, 60, 0);
        chk("t3_err_min", int'(load_err), 1);
        chk("t3_hold_sec", int'(seconds), 10);
        tick(1);
        chk("t3_err_drop", int'(load_err), 0);
        do_load(24, 0, 0);
        chk("t3_err_hr", int'(load_err), 1);
        chk("t3_paused", int'(running), 0);
        do_clear();

        // Pause and resume, then start+pause together
        do_load(0, 0, 10);
        do_start();
        tick(3);
        chk("t4_after3", int'(seconds), 7);
        do_pause();
        tick(5);
        chk("t4_hold", int'(seconds), 7);
        do_start();
        tick(6);
        chk("t4_not_yet", int'(done), 0);
        tick(1);
        chk("t4_done", int'(done), 1);
        tick(6);
        do_load(0, 0, 20);
        do_start();
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1);
        chk("t4_both_pause", int'(running), 0);
        do_clear();

        // Alarm length, load during alarm, start at zero
        do_load(0, 0, 1);
        do_start();
        n_alarm = 0;
        n_done  = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            n_alarm += int'(alarm);
            n_done  += int'(done);
        end
        chk("t5_alarm_len", n_alarm, ALERT_CYCLES);
        chk("t5_done_len", n_done, 1);
        do_load(0, 0, 1);
        do_start();
        tick(2);
        do_load(0, 0, 5);
        chk("t5_alarm_drop", int'(alarm), 0);
        do_clear();
        do_start();
        chk("t5_zero_start", int'(running), 0);

        // Clear mid-run and asynchronous reset mid-alarm
        do_load(0, 30, 0);
        do_start();
        do_clear();
        chk("t6_clear_done", int'(done), 0);
        chk("t6_clear_min", int'(minutes), 0);
        do_load(0, 0, 2);
        do_start();
        tick(3);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_alarm", int'(alarm), 0);
        chk("t6_rst_sec", int'(seconds), 0);
        chk("t6_rst_running", int'(running), 0);
        model_reset();
        check_all();
        #2;
        rst = 1'b0;

        // Random control mix
        for (int i = 0; i < 600; i++) begin
            r  = int'($urandom_range(0, 99));
            c  = (r < 3);
            l  = (r >= 3) && (r < 18);
            pa = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : 0;
            mi = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : 0;
            s  = int'($urandom_range(0, 60));
            step(c, l, h, mi, s, st, pa);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
